// File: rtl/lcd_timing.sv
// LCD dot/line timing generator.
// Produces the current line (LY), dot position, render mode, LY==LYC
// coincidence, line/frame start strobes, and the VBLANK and STAT interrupt
// request pulses. Interrupt pulses are one cycle wide. STAT requests are
// edge-detected on the OR of the enabled sources, so a source hand-over
// with no gap in between does not fire a second request.
module lcd_timing #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int XFER_DOTS     = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [3:0] stat_ie,
  input  logic [7:0] lyc,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic [1:0] mode,
  output logic       coincidence,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_irq,
  output logic       stat_irq
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LY_LAST   = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VIS_LAST  = 8'(VISIBLE_LINES - 1);
  localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  // Registered state; every output port is driven straight from one of these.
  logic [8:0] dot_r;
  logic [7:0] ly_r;
  logic [1:0] mode_r;
  logic       coin_r;
  logic       line_start_r;
  logic       frame_start_r;
  logic       vblank_irq_r;
  logic       stat_irq_r;
  logic       stat_line_r;
  logic       running_r;

  // Next-state values.
  logic [8:0] dot_nx_s;
  logic [7:0] ly_nx_s;
  logic [1:0] mode_nx_s;
  logic       running_nx_s;
  logic       coin_nx_s;
  logic       line_start_s;
  logic       frame_start_s;
  logic       vblank_s;
  logic       adv_s;
  logic       stat_line_s;

  // Dot/line counter advance, start-up after enable, and strobe generation.
  always_comb begin
    dot_nx_s      = dot_r;
    ly_nx_s       = ly_r;
    running_nx_s  = running_r;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;
    vblank_s      = 1'b0;
    adv_s         = 1'b0;
    if (!lcd_enable) begin
      dot_nx_s     = 9'd0;
      ly_nx_s      = 8'd0;
      running_nx_s = 1'b0;
    end else if (dot_en) begin
      adv_s = 1'b1;
      if (!running_r) begin
        // First advancing cycle after enable: the display starts at line 0, dot 0.
        dot_nx_s      = 9'd0;
        ly_nx_s       = 8'd0;
        running_nx_s  = 1'b1;
        line_start_s  = 1'b1;
        frame_start_s = 1'b1;
      end else if (dot_r == DOT_LAST) begin
        dot_nx_s     = 9'd0;
        line_start_s = 1'b1;
        if (ly_r == LY_LAST) begin
          ly_nx_s       = 8'd0;
          frame_start_s = 1'b1;
        end else begin
          ly_nx_s  = ly_r + 8'd1;
          vblank_s = (ly_r == VIS_LAST);
        end
      end else begin
        dot_nx_s = dot_r + 9'd1;
      end
    end else begin
      adv_s = 1'b0;
    end
  end

  // Render mode for the next counter position.
  always_comb begin
    mode_nx_s = MODE_HBLANK;
    if (!running_nx_s) begin
      mode_nx_s = MODE_HBLANK;
    end else if (ly_nx_s >= VIS_LINES) begin
      mode_nx_s = MODE_VBLANK;
    end else if (dot_nx_s < OAM_END) begin
      mode_nx_s = MODE_OAM;
    end else if (dot_nx_s < XFER_END) begin
      mode_nx_s = MODE_XFER;
    end else begin
      mode_nx_s = MODE_HBLANK;
    end
  end

  // Coincidence and the combined STAT interrupt line for the next state.
  always_comb begin
    coin_nx_s   = (ly_nx_s == lyc);
    stat_line_s = 1'b0;
    case (mode_nx_s)
      MODE_HBLANK: stat_line_s = stat_ie[0];
      MODE_VBLANK: stat_line_s = stat_ie[1];
      MODE_OAM:    stat_line_s = stat_ie[2];
      MODE_XFER:   stat_line_s = 1'b0;
      default:     stat_line_s = 1'b0;
    endcase
    stat_line_s = stat_line_s | (stat_ie[3] & coin_nx_s);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_r         <= 9'd0;
      ly_r          <= 8'd0;
      mode_r        <= MODE_HBLANK;
      coin_r        <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      vblank_irq_r  <= 1'b0;
      stat_irq_r    <= 1'b0;
      stat_line_r   <= 1'b0;
      running_r     <= 1'b0;
    end else begin
      dot_r         <= dot_nx_s;
      ly_r          <= ly_nx_s;
      mode_r        <= mode_nx_s;
      running_r     <= running_nx_s;
      coin_r        <= coin_nx_s;
      line_start_r  <= line_start_s;
      frame_start_r <= frame_start_s;
      vblank_irq_r  <= vblank_s;
      if (!lcd_enable) begin
        stat_line_r <= 1'b0;
        stat_irq_r  <= 1'b0;
      end else if (adv_s) begin
        stat_line_r <= stat_line_s;
        stat_irq_r  <= stat_line_s & ~stat_line_r;
      end else begin
        // Paused dot clock: keep the STAT history so no edge is lost or invented.
        stat_line_r <= stat_line_r;
        stat_irq_r  <= 1'b0;
      end
    end
  end

  assign ly          = ly_r;
  assign dot         = dot_r;
  assign mode        = mode_r;
  assign coincidence = coin_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign vblank_irq  = vblank_irq_r;
  assign stat_irq    = stat_irq_r;

endmodule

// File: tb/tb_lcd_timing.sv
// Bench for lcd_timing: the display position is modelled as one linear dot
// count since enable, from which line, dot, mode and strobes are derived.
module tb_lcd_timing;

  localparam int D = 40;
  localparam int O = 8;
  localparam int X = 12;
  localparam int V = 10;
  localparam int T = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dot_en = 1'b0;
  logic       lcd_enable = 1'b0;
  logic [3:0] stat_ie = 4'd0;
  logic [7:0] lyc = 8'd0;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       coincidence, line_start, frame_start, vblank_irq, stat_irq;

  int total = 0;
  int bad = 0;

  // Reference model state.
  bit m_run = 1'b0;
  int m_p = 0;
  bit m_hist = 1'b0;
  int e_ly, e_dot, e_mode, e_coin, e_ls, e_fs, e_vb, e_si;
  int cyc = 0;

  lcd_timing #(.DOTS_PER_LINE(D), .OAM_DOTS(O), .XFER_DOTS(X),
               .VISIBLE_LINES(V), .TOTAL_LINES(T)) dut (
    .clk(clk), .rst_n(rst_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .stat_ie(stat_ie), .lyc(lyc), .ly(ly), .dot(dot), .mode(mode),
    .coincidence(coincidence), .line_start(line_start),
    .frame_start(frame_start), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check_val("ly", int'(ly), e_ly);
    check_val("dot", int'(dot), e_dot);
    check_val("mode", int'(mode), e_mode);
    check_val("coincidence", int'(coincidence), e_coin);
    check_val("line_start", int'(line_start), e_ls);
    check_val("frame_start", int'(frame_start), e_fs);
    check_val("vblank_irq", int'(vblank_irq), e_vb);
    check_val("stat_irq", int'(stat_irq), e_si);
  endtask

  // One clock: apply inputs, advance the model at the edge, compare at negedge.
  task automatic step(input bit en, input bit de);
    bit line;
    lcd_enable = en;
    dot_en = de;
    @(posedge clk);
    cyc++;
    e_ls = 0; e_fs = 0; e_vb = 0; e_si = 0;
    if (!en) begin
      m_run = 1'b0; m_p = 0; m_hist = 1'b0;
    end else if (de) begin
      if (!m_run) begin m_run = 1'b1; m_p = 0; end
      else m_p = (m_p + 1) % (D * T);
    end
    e_ly  = m_run ? m_p / D : 0;
    e_dot = m_run ? m_p % D : 0;
    if (!m_run) e_mode = 0;
    else if (e_ly >= V) e_mode = 1;
    else if (e_dot < O) e_mode = 2;
    else if (e_dot < O + X) e_mode = 3;
    else e_mode = 0;
    e_coin = (e_ly == int'(lyc)) ? 1 : 0;
    if (en && de) begin
      e_ls = (e_dot == 0) ? 1 : 0;
      e_fs = (m_p == 0) ? 1 : 0;
      e_vb = (m_p == V * D) ? 1 : 0;
      line = (stat_ie[3] && e_coin == 1) || (stat_ie[2] && e_mode == 2) ||
             (stat_ie[1] && e_mode == 1) || (stat_ie[0] && e_mode == 0);
      e_si = (line && !m_hist) ? 1 : 0;
      m_hist = line;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int first_ls, second_ls, vb_cnt, si_cnt;
    // Reset state while rst_n is low.
    #12;
    e_ly = 0; e_dot = 0; e_mode = 0; e_coin = 0;
    e_ls = 0; e_fs = 0; e_vb = 0; e_si = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Full-speed frame plus a little, LYC=5 with coincidence interrupt.
    lyc = 8'd5; stat_ie = 4'b1000;
    si_cnt = 0; vb_cnt = 0;
    for (int i = 0; i < D * T + D; i++) begin
      step(1'b1, 1'b1);
      si_cnt += int'(stat_irq);
      vb_cnt += int'(vblank_irq);
      // LYC rewrite during line 6 shows up on the next cycle.
      if (e_ly == 6 && e_dot == 10) lyc = 8'd6;
    end
    check_val("vblank_count", vb_cnt, 1);

    // Mode 0 and mode 1 enables across the visible/vblank boundary.
    stat_ie = 4'b0011; lyc = 8'hFF;
    for (int i = 0; i < D * T; i++) step(1'b1, 1'b1);

    // Disable mid-line, idle, then re-enable.
    for (int i = 0; i < 3 * D + 17; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    stat_ie = 4'b0100;
    for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b1);

    // One dot every four clocks: line period is four times longer.
    first_ls = -1; second_ls = -1;
    for (int k = 0; k < 3 * 4 * D + 8 && second_ls < 0; k++) begin
      step(1'b1, (k % 4) == 0);
      if (line_start) begin
        if (first_ls < 0) first_ls = k; else second_ls = k;
      end
    end
    check_val("gated_line_len", second_ls - first_ls, 4 * D);

    // Random stimulus: sparse dot strobe, occasional config and enable changes.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) stat_ie = 4'($urandom);
      if ($urandom_range(0, 99) == 0) lyc = 8'($urandom_range(0, T));
      step($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-line: outputs clear without a clock edge.
    for (int i = 0; i < D + 7; i++) step(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    e_ly = 0; e_dot = 0; e_mode = 0; e_coin = 0;
    e_ls = 0; e_fs = 0; e_vb = 0; e_si = 0;
    check_all();
    m_run = 1'b0; m_p = 0; m_hist = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D + 3; i++) step(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing.md
LCD_TIMING -- requirements
Module: lcd_timing

Interface
REQ-001 SHALL have parameter DOTS_PER_LINE, default 456: dots per scanline.
REQ-002 SHALL have parameter OAM_DOTS, default 80: length of mode 2 (OAM search) in dots.
REQ-003 SHALL have parameter XFER_DOTS, default 172: length of mode 3 (pixel transfer) in dots.
REQ-004 SHALL have parameter VISIBLE_LINES, default 144: number of visible lines (0..143).
REQ-005 SHALL have parameter TOTAL_LINES, default 154: number of lines per frame including vblank.
REQ-006 SHALL have ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dot_en  in  1  dot strobe; one dot advances per clk cycle with dot_en=1.
- lcd_enable  in  1  LCDC bit 7 (LCDEnable).
- stat_ie  in  4  STAT bits 6:3: [3] coincidence, [2] mode 2, [1] mode 1, [0] mode 0 interrupt enables.
- lyc  in  8  LYC compare value (0xFF45).
- ly  out  8  current line (0xFF44).
- dot  out  9  dot index within line, 0..DOTS_PER_LINE-1.
- mode  out  2  RenderMode: 0 HBLANK, 1 VBLANK, 2 OAM, 3 transfer.
- coincidence  out  1  STAT bit 2, ly==lyc.
- line_start  out  1  one-cycle pulse at dot 0 of every line.
- frame_start  out  1  one-cycle pulse at line 0, dot 0.
- vblank_irq  out  1  one-cycle interrupt request pulse.
- stat_irq  out  1  one-cycle interrupt request pulse.

Function
REQ-007 SHALL keep all outputs registered; each output SHALL reflect the counter state of the same cycle.
REQ-008 On a cycle with dot_en=1 and lcd_enable=1: dot SHALL increment by 1; when dot=DOTS_PER_LINE-1, dot SHALL wrap to 0 and ly SHALL increment by 1.
REQ-009 When ly=TOTAL_LINES-1 and dot wraps, ly SHALL wrap to 0.
REQ-010 When dot_en=0, dot, ly, and mode SHALL hold their values, and no pulse output SHALL assert.
REQ-011 For ly<VISIBLE_LINES, mode SHALL be:
- 2 for dot<OAM_DOTS;
- 3 for OAM_DOTS<=dot<OAM_DOTS+XFER_DOTS;
- 0 otherwise.
REQ-012 For ly>=VISIBLE_LINES, mode SHALL be 1.
REQ-013 coincidence SHALL equal (ly==lyc), re-evaluated every clk cycle regardless of dot_en, so an lyc write is reflected on the next cycle.
REQ-014 line_start SHALL pulse in the first cycle in which dot=0 of a new line; frame_start SHALL additionally pulse when that line is ly=0.
REQ-015 vblank_irq SHALL pulse for exactly one cycle when ly changes from VISIBLE_LINES-1 to VISIBLE_LINES.
REQ-016 The internal STAT line SHALL be the OR of:
- stat_ie[3] & coincidence;
- stat_ie[2] & mode==2;
- stat_ie[1] & mode==1;
- stat_ie[0] & mode==0.
REQ-017 stat_irq SHALL pulse for one cycle only on a 0->1 transition of the STAT line (STAT blocking); a transition between two enabled sources without the line going low SHALL NOT pulse.
REQ-018 When lcd_enable=0:
- ly SHALL be 0, dot SHALL be 0, mode SHALL be 0;
- all pulses SHALL be 0;
- the STAT line history SHALL be cleared to 0;
- coincidence SHALL still track (0==lyc).
REQ-019 On the first cycle with lcd_enable=1 after being 0, the block SHALL start at ly=0, dot=0, mode=2, and SHALL assert line_start and frame_start.
REQ-020 When lcd_enable goes 0 mid-line, counters SHALL reset on the next cycle with no vblank_irq or stat_irq generated by that transition.
REQ-021 Width rule: dot SHALL never exceed DOTS_PER_LINE-1 and ly SHALL never exceed TOTAL_LINES-1; counter widths SHALL hold the default parameters without overflow.

Reset
REQ-022 While rst_n=0, regardless of clk, ly=0, dot=0, mode=0, coincidence=0, and all pulses and STAT line history SHALL be 0.
REQ-023 After rst_n deasserts, the block SHALL behave as in REQ-019 on the first cycle with lcd_enable=1.

Verification
REQ-024 Line timing: enable, dot_en=1 continuously -> mode 2 for dots 0-79, 3 for dots 80-251, 0 for dots 252-455; ly 0->1 after 456 cycles with line_start pulse.
REQ-025 Frame: run 154*456 dot_en cycles -> vblank_irq once at ly 143->144; mode=1 for ly 144-153; ly wraps 153->0 with frame_start.
REQ-026 LYC: lyc=5, stat_ie=4'b1000 -> coincidence=1 and a single stat_irq when ly becomes 5; coincidence=0 at ly=6; lyc write 5->6 during ly=6 -> coincidence next cycle.
REQ-027 Blocking: stat_ie=4'b0011, run across line 143->144 -> a single stat_irq at mode 0 entry, none at mode 0->1 boundary.
REQ-028 Disable/reset mid-frame: lcd_enable=0 at ly=50, dot=200 -> next cycle ly=0, dot=0, mode=0, no pulses; re-enable -> mode 2, frame_start. Asserting rst_n=0 mid-line produces the same outputs asynchronously.
REQ-029 dot_en gating: dot_en toggling 1 of 4 cycles -> line length of 1824 clk cycles, no duplicate pulses.
